// File: rtl/segre_scoreboard_ctrl_if.sv
// Decode-stage issue interface between the ID stage (master) and the scoreboard controller (slave).
interface segre_scoreboard_ctrl_if #(
  parameter int unsigned REG_SIZE = 5
);
  logic                id_valid_i;
  logic [REG_SIZE-1:0] id_src_a_i;
  logic [REG_SIZE-1:0] id_src_b_i;
  logic                id_rd_src_a_i;
  logic                id_rd_src_b_i;
  logic [REG_SIZE-1:0] id_dst_i;
  logic                id_we_i;
  logic [1:0]          id_class_i;
  logic                pipe_hold_i;
  logic                flush_i;
  logic                finish_test_i;
  logic                issue_o;
  logic                stall_id_o;
  logic                inject_nop_ex_o;
  logic                bypass_a_o;
  logic                bypass_b_o;
  logic                busy_o;
  logic                finish_test_o;

  modport master (
    output id_valid_i, id_src_a_i, id_src_b_i, id_rd_src_a_i, id_rd_src_b_i, id_dst_i, id_we_i,
    output id_class_i, pipe_hold_i, flush_i, finish_test_i,
    input  issue_o, stall_id_o, inject_nop_ex_o, bypass_a_o, bypass_b_o, busy_o, finish_test_o
  );

  modport slave (
    input  id_valid_i, id_src_a_i, id_src_b_i, id_rd_src_a_i, id_rd_src_b_i, id_dst_i, id_we_i,
    input  id_class_i, pipe_hold_i, flush_i, finish_test_i,
    output issue_o, stall_id_o, inject_nop_ex_o, bypass_a_o, bypass_b_o, busy_o, finish_test_o
  );
endinterface

// File: rtl/segre_scoreboard_ctrl.sv
// Per-register countdown scoreboard: issue/stall/bypass decisions, write-port slot tracking and
// end-of-test drain sequencing for the ID stage.
module segre_scoreboard_ctrl #(
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned REG_SIZE     = 5,
  parameter int unsigned NUM_CLASSES  = 3,
  parameter int unsigned LAT_ALU      = 1,
  parameter int unsigned LAT_LOAD     = 2,
  parameter int unsigned LAT_MUL      = 5,
  parameter int unsigned FINISH_DELAY = 4,
  parameter int unsigned CNT_W        = $clog2(LAT_MUL + 1)
) (
  input logic                    clk_i,
  input logic                    rst_i,
  segre_scoreboard_ctrl_if.slave sb
);

  localparam int unsigned DlyW = (FINISH_DELAY > 1) ? $clog2(FINISH_DELAY) : 1;

  localparam logic [1:0] FinIdle  = 2'd0;
  localparam logic [1:0] FinDrain = 2'd1;
  localparam logic [1:0] FinDelay = 2'd2;
  localparam logic [1:0] FinDone  = 2'd3;

  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [LAT_MUL:1] ws_q;
  logic [1:0]       fin_q;
  logic [DlyW-1:0]  dly_q;

  logic [1:0]       cls;
  logic [CNT_W-1:0] lat;
  logic [CNT_W-1:0] cnt_a, cnt_b, cnt_dst;
  logic             act_a, act_b, raw_a, raw_b, waw, structural, hazard, alloc, busy;

  // Out-of-range class codes behave as ALU.
  assign cls = (32'(sb.id_class_i) < NUM_CLASSES) ? sb.id_class_i : 2'd0;

  always_comb begin
    lat = CNT_W'(LAT_ALU);
    case (cls)
      2'd1:    lat = CNT_W'(LAT_LOAD);
      2'd2:    lat = CNT_W'(LAT_MUL);
      default: lat = CNT_W'(LAT_ALU);
    endcase
  end

  assign cnt_a   = cnt_q[sb.id_src_a_i];
  assign cnt_b   = cnt_q[sb.id_src_b_i];
  assign cnt_dst = cnt_q[sb.id_dst_i];

  assign act_a = sb.id_rd_src_a_i && (sb.id_src_a_i != '0);
  assign act_b = sb.id_rd_src_b_i && (sb.id_src_b_i != '0);
  assign raw_a = act_a && (cnt_a > CNT_W'(1));
  assign raw_b = act_b && (cnt_b > CNT_W'(1));

  assign waw        = sb.id_we_i && (sb.id_dst_i != '0) && (cnt_dst >= lat);
  assign structural = sb.id_we_i && ws_q[lat];
  assign hazard     = raw_a || raw_b || waw || structural || (fin_q != FinIdle);

  assign sb.issue_o         = sb.id_valid_i && !hazard && !sb.pipe_hold_i && !sb.flush_i;
  assign sb.stall_id_o      = sb.id_valid_i && hazard && !sb.flush_i;
  assign sb.inject_nop_ex_o = sb.stall_id_o || sb.flush_i;
  assign sb.bypass_a_o      = act_a && (cnt_a == CNT_W'(1));
  assign sb.bypass_b_o      = act_b && (cnt_b == CNT_W'(1));
  assign sb.busy_o          = busy;
  assign sb.finish_test_o   = (fin_q == FinDone);

  assign alloc = sb.issue_o && sb.id_we_i && (sb.id_dst_i != '0);

  always_comb begin
    busy = 1'b0;
    for (int r = 1; r < int'(NUM_REGS); r++) begin
      busy = busy | (cnt_q[r] != '0);
    end
  end

  // Allocation is written last so it overrides the same-cycle decrement and slot shift.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < int'(NUM_REGS); r++) begin
        cnt_q[r] <= '0;
      end
      ws_q <= '0;
    end else begin
      if (!sb.pipe_hold_i) begin
        for (int r = 1; r < int'(NUM_REGS); r++) begin
          if (cnt_q[r] != '0) cnt_q[r] <= cnt_q[r] - CNT_W'(1);
        end
        ws_q <= {1'b0, ws_q[LAT_MUL:2]};
      end
      if (alloc) begin
        cnt_q[sb.id_dst_i] <= lat;
        ws_q[lat]          <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fin_q <= FinIdle;
      dly_q <= '0;
    end else begin
      case (fin_q)
        FinIdle: if (sb.finish_test_i) fin_q <= FinDrain;
        FinDrain: begin
          if (!busy) begin
            fin_q <= FinDelay;
            dly_q <= DlyW'(FINISH_DELAY - 1);
          end
        end
        FinDelay: begin
          if (dly_q == '0) fin_q <= FinDone;
          else             dly_q <= dly_q - DlyW'(1);
        end
        default: fin_q <= FinDone;
      endcase
    end
  end

endmodule

// File: tb/tb_segre_scoreboard_ctrl.sv
// Directed bench: each step pushes the hand-derived output vector
// {issue, stall, nop, byp_a, byp_b, busy, finish} and pops/compares it mid-cycle.
module tb_segre_scoreboard_ctrl;

  typedef struct {
    string      tag;
    logic [6:0] exp;
  } sb_entry_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  sb_entry_t sb_q[$];

  segre_scoreboard_ctrl_if #(.REG_SIZE(5)) sif ();

  segre_scoreboard_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .sb    (sif.slave)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [4:0] sa, input logic ra, input logic [4:0] sbr,
                       input logic rb, input logic [4:0] d, input logic w, input logic [1:0] c);
    sif.id_valid_i    = v;
    sif.id_src_a_i    = sa;
    sif.id_rd_src_a_i = ra;
    sif.id_src_b_i    = sbr;
    sif.id_rd_src_b_i = rb;
    sif.id_dst_i      = d;
    sif.id_we_i       = w;
    sif.id_class_i    = c;
  endtask

  task automatic quiet();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
    sif.pipe_hold_i   = 1'b0;
    sif.flush_i       = 1'b0;
    sif.finish_test_i = 1'b0;
  endtask

  task automatic check_head();
    sb_entry_t  e;
    logic [6:0] obs;
    e   = sb_q.pop_front();
    obs = {sif.issue_o, sif.stall_id_o, sif.inject_nop_ex_o, sif.bypass_a_o, sif.bypass_b_o,
           sif.busy_o, sif.finish_test_o};
    n_chk++;
    assert (obs === e.exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [6:0] exp);
    sb_q.push_back('{tag, exp});
    @(negedge clk);
    check_head();
    @(posedge clk);
    #1;
  endtask

  task automatic now_check(input string tag, input logic [6:0] exp);
    sb_q.push_back('{tag, exp});
    check_head();
  endtask

  initial begin
    quiet();
    cyc("reset", 7'b0000000);
    rst = 1'b0;

    // MUL x5, then a non-writing ADD reading x5: stalls while cnt 5..2, bypasses at cnt 1.
    drive(1, 0, 0, 0, 0, 5, 1, 2); cyc("mul_x5", 7'b1000000);
    drive(1, 5, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc("raw_stall", 7'b0110010);
    cyc("raw_bypass_issue", 7'b1001010);
    quiet(); cyc("raw_drained", 7'b0000000);

    // LOAD x7, ALU x8 next cycle (ws[1] free), then a reader of x7/x8 bypasses both.
    drive(1, 0, 0, 0, 0, 7, 1, 1); cyc("load_x7", 7'b1000000);
    drive(1, 0, 0, 0, 0, 8, 1, 0); cyc("alu_x8", 7'b1000010);
    drive(1, 7, 1, 8, 1, 0, 0, 0); cyc("bypass_ab", 7'b1001110);
    quiet(); cyc("load_drained", 7'b0000000);

    // WAW: ALU to x9 held behind MUL to x9 until the counter reaches zero.
    drive(1, 0, 0, 0, 0, 9, 1, 2); cyc("mul_x9", 7'b1000000);
    drive(1, 0, 0, 0, 0, 9, 1, 0);
    for (int i = 0; i < 5; i++) cyc("waw_stall", 7'b0110010);
    cyc("waw_issue", 7'b1000000);
    quiet(); cyc("waw_alu_busy", 7'b0000010);
    cyc("waw_drained", 7'b0000000);

    // Structural: LOAD presented while the MUL write slot sits at ws[2].
    drive(1, 0, 0, 0, 0, 11, 1, 2); cyc("mul_x11", 7'b1000000);
    quiet();
    for (int i = 0; i < 3; i++) cyc("mul_x11_busy", 7'b0000010);
    drive(1, 0, 0, 0, 0, 12, 1, 1); cyc("slot_stall", 7'b0110010);
    cyc("slot_issue", 7'b1000010);
    quiet(); cyc("load_x12_busy0", 7'b0000010);
    cyc("load_x12_busy1", 7'b0000010);
    cyc("slot_drained", 7'b0000000);

    // pipe_hold freezes the counter: two held cycles add two stall cycles.
    drive(1, 0, 0, 0, 0, 14, 1, 2); cyc("mul_x14", 7'b1000000);
    drive(1, 14, 1, 0, 0, 0, 0, 0);
    sif.pipe_hold_i = 1'b1;
    cyc("hold_stall0", 7'b0110010);
    cyc("hold_stall1", 7'b0110010);
    sif.pipe_hold_i = 1'b0;
    for (int i = 0; i < 4; i++) cyc("post_hold_stall", 7'b0110010);
    cyc("post_hold_issue", 7'b1001010);
    quiet(); cyc("hold_drained", 7'b0000000);

    // Flush squashes without allocating; x0 is never tracked.
    drive(1, 0, 0, 0, 0, 15, 1, 0); sif.flush_i = 1'b1;
    cyc("flush_free", 7'b0010000);
    sif.flush_i = 1'b0;
    drive(1, 15, 1, 0, 0, 0, 0, 0); cyc("flush_no_alloc", 7'b1000000);
    drive(1, 0, 0, 0, 0, 0, 1, 2);  cyc("mul_x0", 7'b1000000);
    drive(1, 0, 1, 0, 1, 0, 0, 0);  cyc("read_x0", 7'b1000000);
    drive(1, 0, 0, 0, 0, 16, 1, 2); cyc("mul_x16", 7'b1000000);
    drive(1, 16, 1, 0, 0, 0, 0, 0); sif.flush_i = 1'b1;
    cyc("flush_hazard", 7'b0010010);
    quiet();
    for (int i = 0; i < 4; i++) cyc("x16_busy", 7'b0000010);
    cyc("x16_drained", 7'b0000000);

    // Finish with MUL in flight: drain, then DELAY for FINISH_DELAY cycles, then DONE.
    drive(1, 0, 0, 0, 0, 17, 1, 2); cyc("fin_mul", 7'b1000000);
    quiet(); sif.finish_test_i = 1'b1;
    cyc("fin_req", 7'b0000010);
    sif.finish_test_i = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0, 0); cyc("drain_blocks", 7'b0110010);
    quiet();
    for (int i = 0; i < 3; i++) cyc("draining", 7'b0000010);
    cyc("drain_empty", 7'b0000000);
    cyc("delay0", 7'b0000000);
    drive(1, 0, 0, 0, 0, 0, 0, 0); cyc("delay_blocks", 7'b0110000);
    quiet();
    cyc("delay2", 7'b0000000);
    cyc("delay3", 7'b0000000);
    cyc("done", 7'b0000001);
    drive(1, 0, 0, 0, 0, 0, 0, 0); sif.finish_test_i = 1'b1;
    cyc("done_sticky_blocks", 7'b0110001);
    quiet(); cyc("done_sticky", 7'b0000001);
    rst = 1'b1;
    cyc("reset_clears_done", 7'b0000000);
    rst = 1'b0;

    // Async reset mid-DELAY returns the FSM to idle immediately.
    drive(1, 0, 0, 0, 0, 18, 1, 2); cyc("fin2_mul", 7'b1000000);
    quiet(); sif.finish_test_i = 1'b1;
    cyc("fin2_req", 7'b0000010);
    sif.finish_test_i = 1'b0;
    for (int i = 0; i < 4; i++) cyc("fin2_draining", 7'b0000010);
    cyc("fin2_empty", 7'b0000000);
    cyc("fin2_delay", 7'b0000000);
    rst = 1'b1; #1;
    now_check("rst_mid_delay", 7'b0000000);
    #1 rst = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0, 0); cyc("post_rst_issue", 7'b1000000);
    quiet();
    for (int i = 0; i < 6; i++) cyc("no_finish_after_rst", 7'b0000000);

    // Async reset clears an in-flight counter without waiting for a clock.
    drive(1, 0, 0, 0, 0, 19, 1, 2); cyc("mul_x19", 7'b1000000);
    quiet();
    rst = 1'b1; #1;
    now_check("rst_clears_busy", 7'b0000000);
    #1 rst = 1'b0;
    drive(1, 19, 1, 0, 0, 0, 0, 0); cyc("x19_cleared", 7'b1000000);
    quiet();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
